ccip_c0_rd_arbiter: RTL
=======================

Name: ccip_c0_rd_arbiter

Overview:
- Shares the CCI-P c0 Tx read-request channel among NUM_REQ requesters inside the AFU, in the Clk_400 domain.
- Grants are issued round-robin. Issue is gated by c0TxAlmFull and by an outstanding-read credit limit.
- Each request is tagged in mdata with the requester index, so c0 Rx read responses route back to the requester that issued them.
- Sits between the AFU request engines and the registered CCI-P Tx/Rx ports.

Parameters:
- NUM_REQ, 4, number of requesters (2..16).
- ADDR_W, 42, cache-line address width.
- MAX_OUTSTANDING, 64, maximum reads in flight (1..511).
- IDW, $clog2(NUM_REQ), requester-id width carried in mdata[IDW-1:0].

Ports:
- Clk_400  in  1  CCI-P primary clock; all logic is on its rising edge.
- SoftReset_n  in  1  asynchronous, active-low reset.
- rq_valid  in  NUM_REQ  per-requester read request valid.
- rq_addr  in  NUM_REQ*ADDR_W  per-requester address; slice i is [i*ADDR_W +: ADDR_W].
- rq_ready  out  NUM_REQ  one-hot grant; request i is accepted when rq_valid[i] && rq_ready[i].
- c0Tx_valid  out  1  registered read request valid to CCI-P c0 Tx.
- c0Tx_addr  out  ADDR_W  registered request address.
- c0Tx_mdata  out  16  registered mdata; [IDW-1:0] = requester id, upper bits 0.
- c0TxAlmFull  in  1  CCI-P c0 Tx almost-full.
- c0Rx_rspValid  in  1  read response valid (already filtered for read responses).
- c0Rx_mdata  in  16  mdata of the response.
- rsp_valid  out  NUM_REQ  registered one-hot response strobe to the owning requester.
- outstanding  out  $clog2(MAX_OUTSTANDING+1)  current in-flight count.
- err_sticky  out  1  sticky error flag: response underflow or bad id.

Behaviour:
- Reset (SoftReset_n low, asynchronous): c0Tx_valid=0, c0Tx_addr=0, c0Tx_mdata=0, rsp_valid=0, outstanding=0, err_sticky=0, rr_ptr=0. rq_ready=0 while reset is asserted.
- Reset mid-operation drops any registered request and any in-flight accounting. There is no recovery of lost responses.
- Issue enable: en = !c0TxAlmFull && (outstanding + c0Tx_valid) < MAX_OUTSTANDING. The count includes the request sitting in the output register.
- Arbitration is combinational:
  - If en=1, grant the first i with rq_valid[i]=1, searching rr_ptr, rr_ptr+1, … modulo NUM_REQ.
  - rq_ready = one-hot of that i. rq_ready=0 if en=0 or no request is valid.
  - rq_ready never asserts for a requester whose rq_valid is low.
- Pointer update: on a grant to i, rr_ptr <= (i+1) mod NUM_REQ. With no grant, rr_ptr holds.
- Latency: a request accepted in cycle N gives, in cycle N+1:
  - c0Tx_valid=1;
  - c0Tx_addr = that requester's address;
  - c0Tx_mdata[IDW-1:0] = i.
  With no grant in cycle N, c0Tx_valid=0 in N+1 and addr/mdata hold their previous values.
- At most one request is issued per cycle. Back-to-back grants are allowed.
- Almost-full: when c0TxAlmFull=1 in cycle N, there is no grant in N. A request registered in N-1 still presents in N. The worst-case overrun after almost-full is 1 request, within the CCI-P allowance.
- Outstanding counter: +1 when c0Tx_valid=1; -1 when c0Rx_rspValid=1. Simultaneous increment and decrement leaves it unchanged.
- Underflow: a decrement with outstanding=0 (and no simultaneous increment) saturates at 0 and sets err_sticky.
- Response routing: on c0Rx_rspValid with id = c0Rx_mdata[IDW-1:0]:
  - id < NUM_REQ: rsp_valid[id]=1 in the next cycle, for exactly 1 cycle.
  - id >= NUM_REQ (possible when NUM_REQ is not a power of 2): the response is dropped, err_sticky is set, and the counter still decrements.
- err_sticky clears only on reset.
- Fairness: every continuously-valid requester is granted within NUM_REQ grants.

Test Plan:
- All 4 requesters valid continuously, almFull=0, MAX_OUTSTANDING=64, responses returned 10 cycles after issue → grants in order 0,1,2,3,0,…; c0Tx_valid high every cycle after the first; c0Tx_mdata[1:0] cycles 0..3; outstanding settles at 10.
- Only requester 2 valid, addr=0x123 → rq_ready=4'b0100 in cycle N; in N+1, c0Tx_valid=1, c0Tx_addr=0x123, c0Tx_mdata=16'h0002; rr_ptr=3.
- Raise c0TxAlmFull for 5 cycles with all requesters valid → rq_ready=0 during those cycles; exactly 1 trailing c0Tx_valid after the assertion; grants resume in order from rr_ptr when almFull drops.
- MAX_OUTSTANDING=4, no responses → exactly 4 issues, then rq_ready=0 and outstanding=4. One response with mdata=1 → rsp_valid=4'b0010 the next cycle; exactly 1 more issue follows.
- Simultaneous issue and response in the same cycle with outstanding=3 → outstanding stays 3. A response while outstanding=0 → outstanding stays 0 and err_sticky=1 until reset.
- Assert SoftReset_n=0 mid-burst with outstanding=7 → all outputs 0 asynchronously. After release, the first grant goes to requester 0.

Source files
------------

// File: rtl/ccip_c0_rd_arbiter.sv
// Round-robin arbiter sharing the CCI-P c0 Tx read-request channel among NUM_REQ requesters,
// with outstanding-read credit gating and mdata-tagged response routing back to the issuer.
module ccip_c0_rd_arbiter #(
  parameter int NUM_REQ         = 4,
  parameter int ADDR_W          = 42,
  parameter int MAX_OUTSTANDING = 64,
  parameter int IDW             = $clog2(NUM_REQ),
  localparam int CNT_W          = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                      Clk_400,
  input  logic                      SoftReset_n,
  input  logic [NUM_REQ-1:0]        rq_valid,
  input  logic [NUM_REQ*ADDR_W-1:0] rq_addr,
  output logic [NUM_REQ-1:0]        rq_ready,
  output logic                      c0Tx_valid,
  output logic [ADDR_W-1:0]         c0Tx_addr,
  output logic [15:0]               c0Tx_mdata,
  input  logic                      c0TxAlmFull,
  input  logic                      c0Rx_rspValid,
  input  logic [15:0]               c0Rx_mdata,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [CNT_W-1:0]          outstanding,
  output logic                      err_sticky
);

  logic [IDW-1:0]     rr_ptr;
  logic [IDW-1:0]     ptr_next;
  logic [IDW-1:0]     cand;
  logic [IDW-1:0]     gnt_idx;
  logic               gnt_any;
  logic [NUM_REQ-1:0] gnt_vec;
  logic [CNT_W:0]     in_flight;
  logic               en;
  logic [IDW-1:0]     rsp_id;
  logic [NUM_REQ-1:0] rsp_hit;
  logic               bad_id;
  logic               underflow;

  // The request parked in the output register already holds a credit.
  assign in_flight = {1'b0, outstanding} + {{CNT_W{1'b0}}, c0Tx_valid};
  assign en        = !c0TxAlmFull && (in_flight < (CNT_W+1)'(MAX_OUTSTANDING));

  // NOTE: every output of an always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    gnt_vec = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = IDW'((int'(rr_ptr) + k) % NUM_REQ);
      if (en && !gnt_any && rq_valid[cand]) begin
        gnt_any = 1'b1;
        gnt_idx = cand;
      end
    end
    if (gnt_any) gnt_vec[gnt_idx] = 1'b1;
  end

  assign rq_ready = SoftReset_n ? gnt_vec : '0;
  assign ptr_next = (gnt_idx == IDW'(NUM_REQ - 1)) ? '0 : gnt_idx + IDW'(1);

  // Ids past NUM_REQ-1 match no requester and are flagged as bad.
  assign rsp_id = c0Rx_mdata[IDW-1:0];
  always_comb begin
    rsp_hit = '0;
    for (int k = 0; k < NUM_REQ; k++) rsp_hit[k] = (rsp_id == IDW'(k));
  end
  assign bad_id    = c0Rx_rspValid && !(|rsp_hit);
  assign underflow = c0Rx_rspValid && !c0Tx_valid && (outstanding == '0);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge Clk_400 or negedge SoftReset_n) begin
    if (!SoftReset_n) begin
      rr_ptr      <= '0;
      c0Tx_valid  <= 1'b0;
      c0Tx_addr   <= '0;
      c0Tx_mdata  <= '0;
      rsp_valid   <= '0;
      outstanding <= '0;
      err_sticky  <= 1'b0;
    end else begin
      c0Tx_valid <= gnt_any;
      if (gnt_any) begin
        c0Tx_addr  <= rq_addr[gnt_idx*ADDR_W +: ADDR_W];
        c0Tx_mdata <= 16'(gnt_idx);
        rr_ptr     <= ptr_next;
      end
      rsp_valid <= c0Rx_rspValid ? rsp_hit : '0;
      case ({c0Tx_valid, c0Rx_rspValid})
        2'b10:   outstanding <= outstanding + CNT_W'(1);
        2'b01:   if (outstanding != '0) outstanding <= outstanding - CNT_W'(1);
        default: ;
      endcase
      if (underflow || bad_id) err_sticky <= 1'b1;
    end
  end

endmodule
